// File: rtl/pipe_stage_reg_if.sv
// Valid/ready beat bus carrying a control bundle and a data bundle between
// two adjacent pipeline stages.
interface pipe_stage_reg_if #(
  parameter int unsigned CTRL_W = 10,
  parameter int unsigned DATA_W = 111
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready handshake, flush, optional
// skid entry and saturating stall/bubble counters.
module pipe_stage_reg #(
  parameter int unsigned CTRL_W = 10,
  parameter int unsigned DATA_W = 111,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_i,
  pipe_stage_reg_if.slave       up_if,
  pipe_stage_reg_if.master      dn_if,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      bubble_cnt_o
);

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [CNT_W-1:0]  stall_q,      stall_d;
  logic [CNT_W-1:0]  bubble_q,     bubble_d;

  logic in_ready;
  logic accept;
  logic emit;

  // With the skid entry, in_ready depends only on a register and flush.
  assign in_ready = (SKID != 0) ? (!skid_valid_q && !flush_i)
                                : ((!main_valid_q || dn_if.ready) && !flush_i);
  assign accept   = up_if.valid && in_ready;
  assign emit     = main_valid_q && dn_if.ready;

  assign up_if.ready  = in_ready;
  assign dn_if.valid  = main_valid_q;
  assign dn_if.ctrl   = main_valid_q ? main_ctrl_q : '0;
  assign dn_if.data   = main_data_q;
  assign stall_cnt_o  = stall_q;
  assign bubble_cnt_o = bubble_q;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_ctrl_d  = main_ctrl_q;
    skid_ctrl_d  = skid_ctrl_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;

    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_ctrl_d  = '0;
      skid_ctrl_d  = '0;
    end else if (SKID != 0) begin
      if (!main_valid_q || emit) begin
        // Skid drains ahead of new input; in_ready is low while it is full.
        if (skid_valid_q) begin
          main_valid_d = 1'b1;
          main_ctrl_d  = skid_ctrl_q;
          main_data_d  = skid_data_q;
          skid_valid_d = 1'b0;
        end else if (accept) begin
          main_valid_d = 1'b1;
          main_ctrl_d  = up_if.ctrl;
          main_data_d  = up_if.data;
        end else begin
          main_valid_d = 1'b0;
        end
      end else if (accept) begin
        skid_valid_d = 1'b1;
        skid_ctrl_d  = up_if.ctrl;
        skid_data_d  = up_if.data;
      end
    end else begin
      if (accept) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = up_if.ctrl;
        main_data_d  = up_if.data;
      end else if (emit) begin
        main_valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (main_valid_q && !dn_if.ready && (stall_q != '1))
      stall_d = stall_q + CNT_W'(1);
    if (!main_valid_q && dn_if.ready && (bubble_q != '1))
      bubble_d = bubble_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      skid_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
      stall_q      <= '0;
      bubble_q     <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_ctrl_q  <= skid_ctrl_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
      stall_q      <= stall_d;
      bubble_q     <= bubble_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid, non-skid and 4-bit-counter
// instances driven from one linear stimulus sequence.
module tb_pipe_stage_reg;
  localparam int unsigned CW = 10;
  localparam int unsigned DW = 111;

  logic clk = 1'b0;
  logic reset;
  logic flush_a, flush_b, flush_c;
  logic [15:0] stall_a, bubble_a, stall_b, bubble_b;
  logic [3:0]  stall_c, bubble_c;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) a_up ();
  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) a_dn ();
  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) b_up ();
  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) b_dn ();
  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) c_up ();
  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) c_dn ();

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .flush_i(flush_a), .up_if(a_up), .dn_if(a_dn),
    .stall_cnt_o(stall_a), .bubble_cnt_o(bubble_a));
  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) u_b (
    .clk(clk), .reset(reset), .flush_i(flush_b), .up_if(b_up), .dn_if(b_dn),
    .stall_cnt_o(stall_b), .bubble_cnt_o(bubble_b));
  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(4)) u_c (
    .clk(clk), .reset(reset), .flush_i(flush_c), .up_if(c_up), .dn_if(c_dn),
    .stall_cnt_o(stall_c), .bubble_cnt_o(bubble_c));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    flush_a = 1'b0; flush_b = 1'b0; flush_c = 1'b0;
    a_up.valid = 1'b0; a_up.ctrl = '0; a_up.data = '0; a_dn.ready = 1'b0;
    b_up.valid = 1'b0; b_up.ctrl = '0; b_up.data = '0; b_dn.ready = 1'b0;
    c_up.valid = 1'b0; c_up.ctrl = '0; c_up.data = '0; c_dn.ready = 1'b0;

    // Reset state
    tick;
    chk("rst_out_valid", 128'(a_dn.valid), 128'(0));
    chk("rst_out_ctrl",  128'(a_dn.ctrl),  128'(0));
    chk("rst_out_data",  128'(a_dn.data),  128'(0));
    chk("rst_stall",     128'(stall_a),    128'(0));
    chk("rst_bubble",    128'(bubble_a),   128'(0));
    reset = 1'b0;
    #1 chk("rst_in_ready", 128'(a_up.ready), 128'(1));

    // Streaming, SKID=1: one bubble counted before the first beat lands
    tick;
    a_dn.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_up.valid = 1'b1; a_up.data = DW'(i); a_up.ctrl = CW'(i);
      #1 chk("strm_in_ready", 128'(a_up.ready), 128'(1));
      tick;
      chk("strm_out_valid", 128'(a_dn.valid), 128'(1));
      chk("strm_out_data",  128'(a_dn.data),  128'(i));
      chk("strm_out_ctrl",  128'(a_dn.ctrl),  128'(i));
    end
    a_up.valid = 1'b0;
    tick;
    chk("strm_drained", 128'(a_dn.valid), 128'(0));
    chk("strm_stall",   128'(stall_a),    128'(0));
    chk("strm_bubble",  128'(bubble_a),   128'(1));
    a_dn.ready = 1'b0;

    // Backpressure: A to main, B to skid, C held upstream
    a_up.valid = 1'b1; a_up.data = DW'(32'hA); a_up.ctrl = CW'(1);
    tick;
    chk("bp_a_main", 128'(a_dn.data), 128'(32'hA));
    a_up.data = DW'(32'hB); a_up.ctrl = CW'(2);
    tick;
    chk("bp_skid_full_ready", 128'(a_up.ready), 128'(0));
    chk("bp_a_still",         128'(a_dn.data),  128'(32'hA));
    a_up.data = DW'(32'hC); a_up.ctrl = CW'(3);
    tick;
    chk("bp_c_held_ready", 128'(a_up.ready), 128'(0));
    chk("bp_stall2",       128'(stall_a),    128'(2));
    a_dn.ready = 1'b1;
    tick;
    chk("bp_b_out",     128'(a_dn.data),  128'(32'hB));
    chk("bp_ready_back", 128'(a_up.ready), 128'(1));
    tick;
    chk("bp_c_out",  128'(a_dn.data),  128'(32'hC));
    chk("bp_c_ctrl", 128'(a_dn.ctrl),  128'(3));
    a_up.valid = 1'b0;
    tick;
    chk("bp_drained", 128'(a_dn.valid), 128'(0));
    chk("bp_stall",   128'(stall_a),    128'(2));
    chk("bp_bubble",  128'(bubble_a),   128'(1));
    a_dn.ready = 1'b0;

    // Flush with main and skid full
    a_up.valid = 1'b1; a_up.data = DW'(32'hD1); a_up.ctrl = CW'(10'h055);
    tick;
    a_up.data = DW'(32'hD2); a_up.ctrl = CW'(10'h066);
    tick;
    a_up.data = DW'(32'hEE); a_up.ctrl = 10'h3FF;
    flush_a = 1'b1; a_dn.ready = 1'b1;
    #1;
    chk("fl_in_ready",   128'(a_up.ready), 128'(0));
    chk("fl_pre_valid",  128'(a_dn.valid), 128'(1));
    chk("fl_pre_ctrl",   128'(a_dn.ctrl),  128'(10'h055));
    tick;
    flush_a = 1'b0; a_up.valid = 1'b0;
    chk("fl_out_valid", 128'(a_dn.valid), 128'(0));
    chk("fl_out_ctrl",  128'(a_dn.ctrl),  128'(0));
    chk("fl_data_kept", 128'(a_dn.data),  128'(32'hD1));
    chk("fl_stall",     128'(stall_a),    128'(3));
    #1 chk("fl_ready_back", 128'(a_up.ready), 128'(1));
    tick;
    chk("fl_bubble2", 128'(bubble_a), 128'(2));
    tick;
    chk("fl_bubble3", 128'(bubble_a), 128'(3));
    a_dn.ready = 1'b0;

    // Reset mid-stream with two beats held
    a_up.valid = 1'b1; a_up.data = DW'(32'h11); a_up.ctrl = CW'(1);
    tick;
    a_up.data = DW'(32'h22); a_up.ctrl = CW'(2);
    tick;
    chk("mr_stall_pre", 128'(stall_a), 128'(4));
    a_up.valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mr_out_valid", 128'(a_dn.valid), 128'(0));
    chk("mr_out_ctrl",  128'(a_dn.ctrl),  128'(0));
    chk("mr_stall",     128'(stall_a),    128'(0));
    chk("mr_bubble",    128'(bubble_a),   128'(0));
    tick;
    reset = 1'b0;
    #1 chk("mr_in_ready", 128'(a_up.ready), 128'(1));
    tick;
    chk("mr_still_empty", 128'(a_dn.valid), 128'(0));

    // SKID=0: combinational in_ready
    b_up.valid = 1'b1; b_up.data = DW'(32'h31); b_up.ctrl = CW'(3);
    #1 chk("s0_ready_empty", 128'(b_up.ready), 128'(1));
    tick;
    chk("s0_out_data", 128'(b_dn.data), 128'(32'h31));
    chk("s0_full_ready", 128'(b_up.ready), 128'(0));
    b_up.data = DW'(32'h32); b_up.ctrl = CW'(4); b_dn.ready = 1'b1;
    #1 chk("s0_comb_ready", 128'(b_up.ready), 128'(1));
    tick;
    chk("s0_replace_data", 128'(b_dn.data),  128'(32'h32));
    chk("s0_replace_ctrl", 128'(b_dn.ctrl),  128'(4));
    chk("s0_valid",        128'(b_dn.valid), 128'(1));
    b_up.valid = 1'b0;
    tick;
    chk("s0_bubble_valid", 128'(b_dn.valid), 128'(0));
    chk("s0_bubble_ctrl",  128'(b_dn.ctrl),  128'(0));
    chk("s0_stall",        128'(stall_b),    128'(0));
    b_dn.ready = 1'b0;

    // Saturation, CNT_W=4
    c_up.valid = 1'b1; c_up.data = DW'(32'h5); c_up.ctrl = CW'(5);
    tick;
    c_up.valid = 1'b0;
    for (int i = 0; i < 14; i++) tick;
    chk("sat_14", 128'(stall_c), 128'(14));
    tick;
    chk("sat_15", 128'(stall_c), 128'(15));
    for (int i = 0; i < 5; i++) tick;
    chk("sat_hold", 128'(stall_c), 128'(15));
    chk("sat_bubble", 128'(bubble_c), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register. It replaces the hand-written per-field stage registers (ID/EX and the others) with one reusable block.
- Carries a control bundle and a data bundle, with a valid/ready handshake instead of a bare stall.
- Supports flush: control bits are zeroed and a bubble is inserted. An optional skid entry breaks the combinational ready path.
- Includes saturating stall and bubble counters for performance debug.
- Sits between any two adjacent stages, e.g. decode -> execute.

Parameters:
- CTRL_W, 10, width of control bundle. Default covers branch, memread, memtoreg, aluop[3:0], memwrite, alusrc, regwrite.
- DATA_W, 111, width of data bundle. Default covers imme 32, rs1 5, rs1_data 32, rs2 5, rs2_data 32, rd 5.
- SKID, 1, 1 = two-entry register with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream has a beat
- in_ready  out  1  stage can accept a beat this cycle
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream data bundle
- flush  in  1  synchronous kill of all held beats
- out_valid  out  1  stage holds a valid beat
- out_ready  in  1  downstream accepts this cycle
- out_ctrl  out  CTRL_W  control bundle; forced to 0 when out_valid=0
- out_data  out  DATA_W  data bundle; undefined-but-stable when out_valid=0
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0
- bubble_cnt  out  CNT_W  cycles with out_valid=0 and out_ready=1

Behaviour:
- Reset (async, active-high):
  - main_valid=0, skid_valid=0.
  - Both ctrl registers and both data registers = 0.
  - stall_cnt=0, bubble_cnt=0.
  - Hence out_valid=0, out_ctrl=0, out_data=0. in_ready=1 once reset deasserts.
  - Reset asserted mid-operation discards all held beats immediately.
- Handshakes:
  - Accept = in_valid & in_ready.
  - Emit = out_valid & out_ready.
  - Beats leave in arrival order; none are duplicated or dropped except by flush.
- SKID=0:
  - in_ready = (!main_valid | out_ready) & !flush, combinational.
  - On accept, the main register loads in_*, valid=1. Latency 1 cycle.
  - On emit without accept, main_valid<=0.
  - Full throughput of 1 beat/cycle under continuous out_ready.
- SKID=1:
  - in_ready = !skid_valid & !flush. The skid_valid term is a register; flush is the only combinational term.
  - Accept when main empty, or main emitting with skid empty -> data goes to main.
  - Accept when main valid and not emitting -> data goes to skid.
  - Emit with skid valid -> skid moves to main, skid_valid<=0. in_ready returns the next cycle.
  - Latency 1 cycle; throughput 1 beat/cycle with out_ready held high.
  - At most 2 beats held; in_ready=0 exactly while skid holds a beat.
- Flush:
  - Highest priority after reset. Synchronous: main_valid and skid_valid <= 0, and both ctrl registers <= 0. Data registers are retained.
  - in_ready=0 during the flush cycle, so an in_valid beat in that cycle is not accepted.
  - out_valid of the flush cycle still reflects the pre-flush state. A downstream emit in that same cycle counts as delivered.
- out_ctrl masking: out_ctrl = main_ctrl when main_valid, else 0. A bubble never carries regwrite/memwrite.
- Counters:
  - Evaluated every cycle from the current out_valid/out_ready, flush cycles included.
  - Increment by 1 and saturate at all-ones; no wrap.
  - Cleared only by reset.

Test Plan:
- Reset: assert reset mid-stream with 2 beats held -> out_valid=0, out_ctrl=0, in_ready=1 after release, counters=0.
- Streaming, SKID=1: in_valid=1 for 8 cycles with in_data=1..8, out_ready=1 -> out_data 1..8 on consecutive cycles, each 1 cycle after accept; stall_cnt=0.
- Backpressure, SKID=1: send A, B, C with out_ready=0 -> A in main, B in skid, in_ready=0, C held upstream. Raise out_ready -> A, B, C emitted in order; stall_cnt = number of held cycles.
- Flush with main and skid full, in_valid=1, in_ctrl=10'h3FF -> next cycle out_valid=0, out_ctrl=0, incoming beat not accepted. bubble_cnt increments while out_ready=1.
- SKID=0: out_ready=0 with main full -> in_ready=0 in the same cycle. out_ready=1 with in_valid=1 -> in_ready=1 combinationally, and the new beat replaces the emitted one the next cycle.
- Saturation, CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 4'hF.
